uart_tx_engine: RTL and testbench

Serial transmit engine downstream of the baud-rate decoder. Consumes the decoder's 20-bit per-bit clock count and serializes one parallel byte per load as an asynchronous frame: start bit, 7 or 8 data bits LSB first, optional even/odd parity bit, and one stop bit. Sits between the processor output port (load/data) and the TX pin; tx_rdy is the processor-visible status flag.

---
 rtl/uart_tx_engine.sv | 135 +++++++++++++
 tb/tb_uart_tx_engine.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// Asynchronous serial transmitter: start bit, 7/8 data bits LSB first, optional parity, one stop bit.
// Bit time comes from the live baud_rate count; frame settings are captured at load.
module uart_tx_engine #(
    parameter int BAUD_W = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [BAUD_W-1:0] baud_rate,
    input  logic              load,
    input  logic [7:0]        data_in,
    input  logic              eight,
    input  logic              pen,
    input  logic              ohel,
    output logic              tx,
    output logic              tx_rdy
);

    // state  | meaning
    // IDLE   | line high, ready for load
    // START  | driving start bit (0)
    // DATA   | driving held[idx_q]
    // PARITY | driving parity bit
    // STOP   | driving stop bit (1)
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        held_q, held_d;
    logic              eight_q, eight_d;
    logic              pen_q, pen_d;
    logic              ohel_q, ohel_d;
    logic              tx_q, tx_d;
    logic              rdy_q, rdy_d;

    logic [BAUD_W-1:0] eff_m1;
    logic              tick;
    logic [2:0]        idx_last;
    logic [2:0]        idx_nxt;
    logic              parity;

    // baud_rate of 0 or 1 both mean one clock per bit; >= keeps a shrinking baud_rate from stalling
    assign eff_m1   = (baud_rate <= BAUD_W'(1)) ? '0 : baud_rate - BAUD_W'(1);
    assign tick     = (cnt_q >= eff_m1);
    assign idx_last = eight_q ? 3'd7 : 3'd6;
    assign idx_nxt  = idx_q + 3'd1;
    assign parity   = (^{held_q[7] & eight_q, held_q[6:0]}) ^ ohel_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            held_q  <= '0;
            eight_q <= 1'b0;
            pen_q   <= 1'b0;
            ohel_q  <= 1'b0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            held_q  <= held_d;
            eight_q <= eight_d;
            pen_q   <= pen_d;
            ohel_q  <= ohel_d;
            tx_q    <= tx_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + BAUD_W'(1);
        idx_d   = idx_q;
        held_d  = held_q;
        eight_d = eight_q;
        pen_d   = pen_q;
        ohel_d  = ohel_q;
        tx_d    = tx_q;
        rdy_d   = rdy_q;

        if (state_q == IDLE) begin
            cnt_d = '0;
            tx_d  = 1'b1;
            rdy_d = 1'b1;
            if (load) begin
                held_d  = data_in;
                eight_d = eight;
                pen_d   = pen;
                ohel_d  = ohel;
                state_d = START;
                tx_d    = 1'b0;
                rdy_d   = 1'b0;
            end
        end else if (tick) begin
            cnt_d = '0;
            case (state_q)
                START: begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                    tx_d    = held_q[0];
                end
                DATA: begin
                    if (idx_q == idx_last) begin
                        state_d = pen_q ? PARITY : STOP;
                        tx_d    = pen_q ? parity : 1'b1;
                    end else begin
                        idx_d = idx_nxt;
                        tx_d  = held_q[idx_nxt];
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
                STOP: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    rdy_d   = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    rdy_d   = 1'b1;
                end
            endcase
        end
    end

    assign tx     = tx_q;
    assign tx_rdy = rdy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: table of frames with hand-computed parity and length,
// plus sequences for async reset, ignored mid-frame load and back-to-back frames.
module tb_uart_tx_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [19:0] baud_rate = 20'd4;
    logic        load = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        eight = 1'b1;
    logic        pen = 1'b0;
    logic        ohel = 1'b0;
    logic        tx;
    logic        tx_rdy;

    int checks = 0;
    int failures = 0;

    uart_tx_engine #(.BAUD_W(20)) dut (
        .clk(clk), .reset_n(reset_n), .baud_rate(baud_rate), .load(load),
        .data_in(data_in), .eight(eight), .pen(pen), .ohel(ohel),
        .tx(tx), .tx_rdy(tx_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         baud;
        logic [7:0] data;
        logic       eight;
        logic       pen;
        logic       ohel;
        logic       par;   // hand-computed parity bit
        int         len;   // hand-computed frame length in bits
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_bit(input vec_t v, input int b);
        int n;
        n = v.eight ? 8 : 7;
        if (b == 0) return 1'b0;
        if (b <= n) return v.data[b-1];
        if (v.pen && b == n + 1) return v.par;
        return 1'b1;
    endfunction

    // Drive a load pulse; afterwards scramble the frame inputs unless load is held.
    task automatic start_frame(input vec_t v, input bit hold);
        @(negedge clk);
        baud_rate = 20'(v.baud);
        data_in   = v.data;
        eight     = v.eight;
        pen       = v.pen;
        ohel      = v.ohel;
        load      = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            load    = 1'b0;
            data_in = ~v.data;
            eight   = ~v.eight;
            pen     = ~v.pen;
            ohel    = ~v.ohel;
        end
    endtask

    // mode 0: plain, 1: inject an ignored load of 8'h00 in bit 3, 2: drop load at first cycle
    task automatic check_frame(input vec_t v, input int mode, input string tag);
        int   eff;
        bit   ok;
        logic e;
        logic seen_tx;
        logic seen_rdy;
        eff = (v.baud <= 1) ? 1 : v.baud;
        for (int b = 0; b < v.len; b++) begin
            ok = 1'b1;
            e = exp_bit(v, b);
            seen_tx = e;
            seen_rdy = 1'b0;
            for (int c = 0; c < eff; c++) begin
                @(negedge clk);
                if (mode == 2 && b == 0 && c == 0) load = 1'b0;
                if (mode == 1 && b == 3 && c == 0) begin load = 1'b1; data_in = 8'h00; end
                if (mode == 1 && b == 3 && c == 1) load = 1'b0;
                if (tx !== e || tx_rdy !== 1'b0) begin
                    ok = 1'b0;
                    seen_tx = tx;
                    seen_rdy = tx_rdy;
                end
            end
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL %s bit%0d: got tx=%b tx_rdy=%b expected tx=%b tx_rdy=0",
                         tag, b, seen_tx, seen_rdy, e);
            end
        end
        @(negedge clk);
        check({tag, " rdy_rise"}, {30'd0, tx_rdy, tx}, 32'b11);
    endtask

    initial begin
        vecs[0] = '{baud: 4,   data: 8'hA5, eight: 1, pen: 0, ohel: 0, par: 0, len: 10};
        vecs[1] = '{baud: 4,   data: 8'h07, eight: 1, pen: 1, ohel: 0, par: 1, len: 11};
        vecs[2] = '{baud: 4,   data: 8'h07, eight: 1, pen: 1, ohel: 1, par: 0, len: 11};
        vecs[3] = '{baud: 4,   data: 8'hFF, eight: 0, pen: 1, ohel: 0, par: 1, len: 10};
        vecs[4] = '{baud: 0,   data: 8'h3C, eight: 1, pen: 0, ohel: 0, par: 0, len: 10};
        vecs[5] = '{baud: 1,   data: 8'h3C, eight: 1, pen: 0, ohel: 0, par: 0, len: 10};
        vecs[6] = '{baud: 3,   data: 8'h80, eight: 0, pen: 1, ohel: 1, par: 1, len: 10};
        vecs[7] = '{baud: 2,   data: 8'h81, eight: 1, pen: 1, ohel: 0, par: 0, len: 11};
        vecs[8] = '{baud: 868, data: 8'h55, eight: 1, pen: 0, ohel: 0, par: 0, len: 10};

        repeat (3) @(negedge clk);
        check("reset_state", {30'd0, tx_rdy, tx}, 32'b11);
        reset_n = 1'b1;

        begin
            bit ok_idle;
            ok_idle = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (tx !== 1'b1 || tx_rdy !== 1'b1) ok_idle = 1'b0;
            end
            check("idle_20", {31'd0, ok_idle}, 32'd1);
        end

        for (int i = 0; i < 9; i++) begin
            start_frame(vecs[i], 1'b0);
            check_frame(vecs[i], 0, $sformatf("vec%0d", i));
        end

        // ignored load mid-frame, then no second frame
        start_frame(vecs[0], 1'b0);
        check_frame(vecs[0], 1, "midload");
        begin
            bit ok_idle;
            ok_idle = 1'b1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (tx !== 1'b1 || tx_rdy !== 1'b1) ok_idle = 1'b0;
            end
            check("midload_no_second", {31'd0, ok_idle}, 32'd1);
        end

        // load held high: frame 2 starts on the edge after tx_rdy rises
        start_frame(vecs[1], 1'b1);
        check_frame(vecs[1], 0, "b2b_first");
        check_frame(vecs[1], 2, "b2b_second");

        // async reset mid start bit
        start_frame(vecs[0], 1'b0);
        repeat (2) @(negedge clk);
        check("pre_reset_start", {30'd0, tx_rdy, tx}, 32'b00);
        reset_n = 1'b0;
        #1;
        check("async_reset", {30'd0, tx_rdy, tx}, 32'b11);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", {30'd0, tx_rdy, tx}, 32'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
